nibble_serial_add_ctrl: RTL and testbench
=========================================

# nibble_serial_add_ctrl

Sequencing controller that performs a WIDTH-bit add or subtract by driving an external 4-bit ripple adder one nibble per clock, least-significant nibble first. It sits directly upstream of the 4-bit adder, feeding its A/B/c_in inputs, and directly downstream of it, capturing S/c_out into a result register. It latches its operands on a Run request, runs WIDTH/4 add cycles, then presents Sum/Cout/Overflow with a one-cycle Done pulse.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8; N = WIDTH/4 nibble steps.

- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- Run  in  1  start request, rising-edge triggered (sampled and compared with registered copy Run_q).
- Sub  in  1  0 = A+B, 1 = A−B; sampled with operands.
- A_in  in  WIDTH  operand A.
- B_in  in  WIDTH  operand B.
- add_a  out  4  nibble of A to adder.
- add_b  out  4  nibble of effective B to adder.
- add_cin  out  1  carry into adder.
- add_s  in  4  adder sum nibble.
- add_cout  in  1  adder carry out.
- Sum  out  WIDTH  result register.
- Cout  out  1  final carry out (for Sub: 1 = no borrow).
- Overflow  out  1  two's-complement signed overflow.
- Busy  out  1  high in ADD and DONE.
- Done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, ADD, DONE.
- IDLE: start = Run & ~Run_q. On start: opA <= A_in; opB <= Sub ? ~B_in : B_in; carry <= Sub; idx <= 0; Sum <= 0; Cout <= 0; Overflow <= 0; go ADD. Run held high never retriggers; Run must go low for at least one cycle before another start.
- ADD: add_a = opA[4·idx+3 : 4·idx], add_b = opB[same], add_cin = carry (combinational from registers). Each edge: Sum[4·idx+3 : 4·idx] <= add_s; carry <= add_cout; idx <= idx+1. On the edge where idx = N−1: Cout <= add_cout; Overflow <= (opA[WIDTH−1] == opB[WIDTH−1]) & (add_s[3] != opA[WIDTH−1]); go DONE.
- DONE: Done = 1 for exactly this cycle; next edge go IDLE unconditionally.
- Outside ADD, add_a/add_b/add_cin drive 0.
- Sum, Cout and Overflow hold the last result until the next start.
- Run and Sub edges during ADD/DONE are ignored. Run_q still tracks Run, so a Run rising during ADD does not start a new operation on return to IDLE.
- Arithmetic is modulo 2^WIDTH. idx is a clog2(N)-bit counter with no wrap beyond N−1.

## Timing
- Reset values, asynchronous on Reset_n low: state IDLE, idx 0, carry 0, Run_q 0, opA/opB 0, Sum 0, Cout 0, Overflow 0, Busy 0, Done 0, add_* 0.
- Reset asserted mid-operation aborts immediately. The partial Sum is discarded (cleared to 0), and no Done is produced.
- Edge E0 samples the start condition. Edges E1..EN capture nibbles 0..N−1. Done is high in the cycle after EN. The result is valid from EN onward. Latency from the start edge to Done is N cycles; for WIDTH=16, Done is high in cycle 4 after E0.
- Minimum start-to-start spacing is N+2 cycles, provided Run toggles low and high in time.
- The external adder is combinational; its path add_a → add_s must close within one Clk period.

## Test plan
- WIDTH=16, A=0x1234, B=0x4321, Sub=0, Run pulse -> after exactly 4 edges Sum=0x5555, Cout=0, Overflow=0, Done high 1 cycle, Busy high 5 cycles.
- A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, Cout=1, Overflow=0 (carry ripples through all 4 nibbles via the carry register).
- A=0x7FFF, B=0x0001, Sub=0 -> Sum=0x8000, Cout=0, Overflow=1. Then A=0x8000, B=0x0001, Sub=1 -> Sum=0x7FFF, Cout=1, Overflow=1.
- A=0x0005, B=0x0007, Sub=1 -> Sum=0xFFFE, Cout=0. Check add_cin=1 on the first ADD cycle and add_b=~0x7 nibble-wise.
- Run held high for 20 cycles -> exactly one operation and one Done pulse. Change A_in during ADD -> result unaffected.
- Reset_n low during the 2nd ADD cycle -> all outputs 0 asynchronously, no Done. Then a fresh Run completes normally.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Host and nibble-adder signal bundle for nibble_serial_add_ctrl.
// slave = controller side, master = host/adder side.
interface nibble_serial_add_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             Run;
  logic             Sub;
  logic [WIDTH-1:0] A_in;
  logic [WIDTH-1:0] B_in;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_s;
  logic             add_cout;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
  logic             Busy;
  logic             Done;

  modport slave (
    input  Run, Sub, A_in, B_in,
    input  add_s, add_cout,
    output add_a, add_b, add_cin,
    output Sum, Cout, Overflow,
    output Busy, Done
  );

  modport master (
    output Run, Sub, A_in, B_in,
    output add_s, add_cout,
    input  add_a, add_b, add_cin,
    input  Sum, Cout, Overflow,
    input  Busy, Done
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Serial WIDTH-bit add/sub sequencer driving an external
// 4-bit adder one nibble per clock, LS nibble first.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                     Clk,
  input logic                     Reset_n,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic             run_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             start;
  logic             last;
  logic [IW+1:0]    bit_lo;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             nib_cin;

  assign start  = bus.Run & ~run_q;
  assign last   = (idx == IW'(N - 1));
  assign bit_lo = {idx, 2'b00};

  always_comb begin
    nib_a   = '0;
    nib_b   = '0;
    nib_cin = 1'b0;
    if (state == S_ADD) begin
      nib_a   = op_a[bit_lo +: 4];
      nib_b   = op_b[bit_lo +: 4];
      nib_cin = carry;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      run_q  <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      run_q <= bus.Run;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_a   <= bus.A_in;
            op_b   <= bus.Sub ? ~bus.B_in : bus.B_in;
            carry  <= bus.Sub;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          sum_q[bit_lo +: 4] <= bus.add_s;
          carry <= bus.add_cout;
          if (last) begin
            idx    <= '0;
            cout_q <= bus.add_cout;
            // signed overflow: like-signed inputs, result sign differs
            ovf_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &
                      (bus.add_s[3] != op_a[WIDTH-1]);
            state  <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.add_a    = nib_a;
  assign bus.add_b    = nib_b;
  assign bus.add_cin  = nib_cin;
  assign bus.Sum      = sum_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;
  assign bus.Busy     = (state != S_IDLE);
  assign bus.Done     = (state == S_DONE);
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized bench for nibble_serial_add_ctrl with an
// arithmetic reference model and a per-cycle compare.
module tb_nibble_serial_add_ctrl;
  localparam int W = 16;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;

  nibble_serial_add_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // external combinational 4-bit adder
  assign {bus.add_cout, bus.add_s} =
    {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0, bus.add_cin};

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // reference model: phase 0 idle, 1..4 nibble steps, 5 done
  int         m_phase = 0;
  logic [15:0] m_a = '0, m_beff = '0, m_res = '0;
  logic        m_sub = 0, m_cout = 0, m_ovf = 0, m_run_prev = 0;

  always @(posedge Clk or negedge Reset_n) begin
    logic [16:0] full;
    if (!Reset_n) begin
      m_phase = 0; m_a = '0; m_beff = '0; m_res = '0;
      m_sub = 0; m_cout = 0; m_ovf = 0; m_run_prev = 0;
    end else begin
      if (m_phase == 0) begin
        if (bus.Run && !m_run_prev) begin
          m_a    = bus.A_in;
          m_sub  = bus.Sub;
          m_beff = m_sub ? ~bus.B_in : bus.B_in;
          if (m_sub) begin
            m_res  = bus.A_in - bus.B_in;
            m_cout = (bus.A_in >= bus.B_in);
            m_ovf  = (bus.A_in[15] != bus.B_in[15]) &&
                     (m_res[15] != bus.A_in[15]);
          end else begin
            full   = {1'b0, bus.A_in} + {1'b0, bus.B_in};
            m_res  = full[15:0];
            m_cout = full[16];
            m_ovf  = (bus.A_in[15] == bus.B_in[15]) &&
                     (m_res[15] != bus.A_in[15]);
          end
          m_phase = 1;
        end
      end else if (m_phase == 5) m_phase = 0;
      else m_phase++;
      m_run_prev = bus.Run;
    end
  end

  always @(negedge Clk) begin
    int k;
    logic [31:0] es, ea, eb, ec, lowm;
    logic ecout, eovf;
    if (bus.Done) done_cnt++;
    if (bus.Busy) busy_cnt++;
    k = m_phase - 1;
    if (m_phase == 0) es = 32'(m_res);
    else es = 32'(m_res) & ((32'h1 << (4 * k)) - 1);
    ecout = (m_phase == 0 || m_phase == 5) ? m_cout : 1'b0;
    eovf  = (m_phase == 0 || m_phase == 5) ? m_ovf : 1'b0;
    ea = 0; eb = 0; ec = 0;
    if (m_phase >= 1 && m_phase <= 4) begin
      lowm = (32'h1 << (4 * k)) - 1;
      ea = (32'(m_a) >> (4 * k)) & 32'hF;
      eb = (32'(m_beff) >> (4 * k)) & 32'hF;
      ec = (((32'(m_a) & lowm) + (32'(m_beff) & lowm) + 32'(m_sub))
            >> (4 * k)) & 32'h1;
    end
    chk("busy", 32'(bus.Busy), 32'(m_phase != 0));
    chk("done", 32'(bus.Done), 32'(m_phase == 5));
    chk("sum", 32'(bus.Sum), es);
    chk("cout", 32'(bus.Cout), 32'(ecout));
    chk("ovf", 32'(bus.Overflow), 32'(eovf));
    chk("add_a", 32'(bus.add_a), ea);
    chk("add_b", 32'(bus.add_b), eb);
    chk("add_cin", 32'(bus.add_cin), ec);
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic s, output logic [3:0] b0,
                        output logic cin0, output int lat);
    @(negedge Clk); #2;
    bus.A_in = a; bus.B_in = b; bus.Sub = s; bus.Run = 1'b1;
    @(negedge Clk);
    b0 = bus.add_b; cin0 = bus.add_cin;
    #2 bus.Run = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (bus.Done) begin lat = i; break; end
    end
    if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_res(input string nm, input logic [15:0] s,
                           input logic c, input logic o);
    chk({nm, "_sum"}, 32'(bus.Sum), 32'(s));
    chk({nm, "_cout"}, 32'(bus.Cout), 32'(c));
    chk({nm, "_ovf"}, 32'(bus.Overflow), 32'(o));
  endtask

  initial begin
    logic [3:0] b0;
    logic cin0;
    int lat;
    bus.Run = 0; bus.Sub = 0; bus.A_in = '0; bus.B_in = '0;
    #1 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_sum", 32'(bus.Sum), 32'd0);
    chk("rst_flags", 32'({bus.Cout, bus.Overflow, bus.Busy, bus.Done}),
        32'd0);
    chk("rst_add", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    #1 Reset_n = 1'b1;

    busy_cnt = 0; done_cnt = 0;
    run_op(16'h1234, 16'h4321, 1'b0, b0, cin0, lat);
    chk("t1_lat", 32'(lat), 32'd4);
    check_res("t1", 16'h5555, 1'b0, 1'b0);
    @(negedge Clk); #1;
    chk("t1_busy_cycles", 32'(busy_cnt), 32'd5);
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);

    run_op(16'hFFFF, 16'h0001, 1'b0, b0, cin0, lat);
    check_res("t2", 16'h0000, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, b0, cin0, lat);
    check_res("t3a", 16'h8000, 1'b0, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1, b0, cin0, lat);
    check_res("t3b", 16'h7FFF, 1'b1, 1'b1);
    run_op(16'h0005, 16'h0007, 1'b1, b0, cin0, lat);
    check_res("t4", 16'hFFFE, 1'b0, 1'b0);
    chk("t4_cin0", 32'(cin0), 32'd1);
    chk("t4_b0", 32'(b0), 32'h8);

    // Run held high with operands changing mid-operation
    @(negedge Clk); #2;
    done_cnt = 0;
    bus.A_in = 16'h1111; bus.B_in = 16'h2222; bus.Sub = 0; bus.Run = 1;
    repeat (2) @(negedge Clk);
    #2 bus.A_in = 16'hFFFF; bus.B_in = 16'h0000; bus.Sub = 1;
    repeat (18) @(negedge Clk);
    #2 bus.Run = 0;
    repeat (3) @(negedge Clk);
    #1;
    chk("hold_done_pulses", 32'(done_cnt), 32'd1);
    check_res("hold", 16'h3333, 1'b0, 1'b0);

    // asynchronous reset in the 2nd ADD cycle
    @(negedge Clk); #2;
    done_cnt = 0;
    bus.A_in = 16'h1234; bus.B_in = 16'h1111; bus.Sub = 0; bus.Run = 1;
    @(negedge Clk); #2 bus.Run = 0;
    @(negedge Clk); #1;
    chk("pre_rst_partial", 32'(bus.Sum), 32'h0005);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_sum", 32'(bus.Sum), 32'd0);
    chk("arst_flags", 32'({bus.Cout, bus.Overflow, bus.Busy, bus.Done}),
        32'd0);
    chk("arst_add", 32'({bus.add_a, bus.add_b, bus.add_cin}), 32'd0);
    repeat (3) @(negedge Clk);
    #2 Reset_n = 1'b1;
    chk("arst_no_done", 32'(done_cnt), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, b0, cin0, lat);
    check_res("post_rst", 16'h0100, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), b0, cin0, lat);
      chk("rand_lat", 32'(lat), 32'd4);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
